// File: rtl/knight_scan_seq.sv
// Knight Rider scan sequencer: a full-brightness head sweeps back and forth across
// the LED row while every level decays geometrically on each step tick.
module knight_scan_seq #(
    parameter int N_LEDS      = 8,
    parameter int LEVEL_W     = 8,
    parameter int DECAY_SHIFT = 1,
    parameter int END_HOLD    = 0,
    parameter int POS_W       = $clog2(N_LEDS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        step,
    input  logic                        enable,
    output logic [N_LEDS*LEVEL_W-1:0]   levels,
    output logic [POS_W-1:0]            head_pos,
    output logic                        direction,
    output logic                        update
);

    localparam int HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD + 1) : 1;

    localparam logic [LEVEL_W-1:0] MAX       = '1;
    localparam logic [POS_W-1:0]   LAST      = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]   FIRST     = '0;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(END_HOLD);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [LEVEL_W-1:0]  lvl [N_LEDS];
    logic [POS_W-1:0]    pos_inc;
    logic [POS_W-1:0]    pos_dec;

    assign pos_inc = head_pos + 1'b1;
    assign pos_dec = head_pos - 1'b1;

    for (genvar g = 0; g < N_LEDS; g++) begin : g_pack
        assign levels[g*LEVEL_W +: LEVEL_W] = lvl[g];
    end

    // Any move that lands on an end LED enters that end's hold state, which
    // keeps a 2-LED row from ever stepping past its last index.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LEDS; i++) begin
                lvl[i] <= '0;
            end
            head_pos  <= '0;
            direction <= 1'b0;
            update    <= 1'b0;
            state     <= UP;
            hold_cnt  <= '0;
        end else begin
            update <= step;
            if (step) begin
                for (int i = 0; i < N_LEDS; i++) begin
                    lvl[i] <= lvl[i] >> DECAY_SHIFT;
                end
                if (enable) begin
                    case (state)
                        UP: begin
                            head_pos     <= pos_inc;
                            lvl[pos_inc] <= MAX;
                            direction    <= 1'b0;
                            if (pos_inc == LAST) begin
                                state    <= HOLD_HI;
                                hold_cnt <= HOLD_INIT;
                            end
                        end
                        HOLD_HI: begin
                            if (hold_cnt == '0) begin
                                head_pos     <= pos_dec;
                                lvl[pos_dec] <= MAX;
                                direction    <= 1'b1;
                                if (pos_dec == FIRST) begin
                                    state    <= HOLD_LO;
                                    hold_cnt <= HOLD_INIT;
                                end else begin
                                    state <= DOWN;
                                end
                            end else begin
                                hold_cnt      <= hold_cnt - 1'b1;
                                lvl[head_pos] <= MAX;
                            end
                        end
                        DOWN: begin
                            head_pos     <= pos_dec;
                            lvl[pos_dec] <= MAX;
                            direction    <= 1'b1;
                            if (pos_dec == FIRST) begin
                                state    <= HOLD_LO;
                                hold_cnt <= HOLD_INIT;
                            end
                        end
                        HOLD_LO: begin
                            if (hold_cnt == '0) begin
                                head_pos     <= pos_inc;
                                lvl[pos_inc] <= MAX;
                                direction    <= 1'b0;
                                if (pos_inc == LAST) begin
                                    state    <= HOLD_HI;
                                    hold_cnt <= HOLD_INIT;
                                end else begin
                                    state <= UP;
                                end
                            end else begin
                                hold_cnt      <= hold_cnt - 1'b1;
                                lvl[head_pos] <= MAX;
                            end
                        end
                        default: begin
                            state <= UP;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_knight_scan_seq.sv
// Directed bench for knight_scan_seq: default row, an END_HOLD=2 row and a
// 2-LED row all share one stimulus stream, with hand-computed expectations.
module tb_knight_scan_seq;

    logic        clock;
    logic        reset_n;
    logic        step;
    logic        enable;

    logic [63:0] levels;
    logic [2:0]  head_pos;
    logic        direction;
    logic        update;

    logic [63:0] levels_h;
    logic [2:0]  head_pos_h;
    logic        direction_h;
    logic        update_h;

    logic [15:0] levels_2;
    logic [0:0]  head_pos_2;
    logic        direction_2;
    logic        update_2;

    int total = 0;
    int bad   = 0;

    knight_scan_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .step      (step),
        .enable    (enable),
        .levels    (levels),
        .head_pos  (head_pos),
        .direction (direction),
        .update    (update)
    );

    knight_scan_seq #(.END_HOLD(2)) dut_h (
        .clock     (clock),
        .reset_n   (reset_n),
        .step      (step),
        .enable    (enable),
        .levels    (levels_h),
        .head_pos  (head_pos_h),
        .direction (direction_h),
        .update    (update_h)
    );

    knight_scan_seq #(.N_LEDS(2)) dut_2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .step      (step),
        .enable    (enable),
        .levels    (levels_2),
        .head_pos  (head_pos_2),
        .direction (direction_2),
        .update    (update_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] led(input logic [63:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic applyStimulus(input logic rn, input logic s, input logic e);
        @(negedge clock);
        reset_n = rn;
        step    = s;
        enable  = e;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        step    = 1'b0;
        enable  = 1'b1;

        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("rst_levels", levels, 64'd0);
            checkOutput("rst_head", head_pos, 0);
            checkOutput("rst_dir", direction, 0);
            checkOutput("rst_update", update, 0);
        end

        for (int s = 1; s <= 7; s++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("sweep_head", head_pos, s);
            checkOutput("sweep_update", update, 1);
        end
        checkOutput("s7_dir", direction, 0);
        checkOutput("s7_led7", led(levels, 7), 255);
        checkOutput("s7_led6", led(levels, 6), 127);
        checkOutput("s7_led5", led(levels, 5), 63);
        checkOutput("s7_led4", led(levels, 4), 31);
        checkOutput("s7_led1", led(levels, 1), 3);
        checkOutput("s7_led0", led(levels, 0), 0);
        checkOutput("h_s7_head", head_pos_h, 7);
        checkOutput("n2_s7_head", head_pos_2, 1);
        checkOutput("n2_s7_dir", direction_2, 0);

        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("s8_head", head_pos, 6);
        checkOutput("s8_dir", direction, 1);
        checkOutput("s8_led6", led(levels, 6), 255);
        checkOutput("s8_led7", led(levels, 7), 127);
        checkOutput("h_s8_head", head_pos_h, 7);
        checkOutput("n2_s8_head", head_pos_2, 0);
        checkOutput("n2_s8_dir", direction_2, 1);

        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("h_s9_head", head_pos_h, 7);
        checkOutput("h_s9_dir", direction_h, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("h_s10_head", head_pos_h, 6);
        checkOutput("h_s10_dir", direction_h, 1);
        checkOutput("s10_head", head_pos, 4);

        for (int s = 11; s <= 16; s++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
        end
        checkOutput("h_s16_head", head_pos_h, 0);
        checkOutput("s16_head", head_pos, 2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("h_s17_head", head_pos_h, 0);
        checkOutput("s17_head", head_pos, 3);
        checkOutput("s17_dir", direction, 0);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("dis_head", head_pos, 3);
        checkOutput("dis_led3", led(levels, 3), 127);
        checkOutput("dis_update", update, 1);
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkOutput("fade_levels", levels, 64'd0);
        checkOutput("fade_head", head_pos, 3);
        checkOutput("h_fade_head", head_pos_h, 0);

        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reen_head", head_pos, 4);
        checkOutput("reen_led4", led(levels, 4), 255);
        checkOutput("h_reen_head", head_pos_h, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("h_leave_head", head_pos_h, 1);
        checkOutput("h_leave_dir", direction_h, 0);
        checkOutput("pre_burst_head", head_pos, 5);

        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            checkOutput("burst_update", update, 1);
        end
        checkOutput("burst_head", head_pos, 5);
        checkOutput("burst_dir", direction, 1);

        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("idle_update", update, 0);
            checkOutput("idle_head", head_pos, 5);
            checkOutput("idle_led4", led(levels, 4), 7);
            checkOutput("idle_led5", led(levels, 5), 255);
            checkOutput("idle_led6", led(levels, 6), 127);
            checkOutput("idle_led7", led(levels, 7), 63);
        end

        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("mid_rst_levels", levels, 64'd0);
        checkOutput("mid_rst_head", head_pos, 0);
        checkOutput("mid_rst_dir", direction, 0);
        checkOutput("mid_rst_update", update, 0);
        checkOutput("n2_rst_head", head_pos_2, 0);

        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("post_rst_head", head_pos, 1);
        checkOutput("post_rst_led1", led(levels, 1), 255);
        checkOutput("post_rst_update", update, 1);
        checkOutput("n2_post_rst_head", head_pos_2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
